fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, in-order response tracking, IF/ID instruction buffer.
// Response-to-decode latency 1 cycle; decode stall backpressures imem through the queue+outstanding credit limit.

module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] instruction,
    output logic [31:0] instructionPc,
    output logic        instructionValid
);
    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_S = QUEUE_DEPTH[CW:0];
    localparam logic [CW-1:0] DEPTH_C = QUEUE_DEPTH[CW-1:0];
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ibuf_entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] out_after_resp;

    ibuf_entry_t   q_head, q_in;
    logic [CW-1:0] q_count;
    logic          q_empty, q_full, q_pop;

    logic [31:0]   fl_head_pc;
    logic [CW-1:0] fl_count;
    logic          fl_empty, fl_full;

    logic [CW:0]   credit_used;
    logic          req_fire, resp_trk, resp_keep;

    assign credit_used  = {1'b0, outstanding_q} + {1'b0, q_count};
    assign imemReqValid = !reset && !redirectValid && (credit_used < DEPTH_S);
    assign imemReqAddr  = pc_q & 32'hFFFF_FFFC;
    assign req_fire     = imemReqValid && imemReqReady;

    // Responses with nothing in flight (e.g. left over from before a reset) are ignored.
    assign resp_trk  = imemRespValid && !fl_empty;
    assign resp_keep = resp_trk && (drop_q == '0) && !redirectValid;
    assign q_pop     = !q_empty && !stall && !redirectValid;
    assign q_in      = '{word: imemRespData, pc: fl_head_pc};

    assign instructionValid = !q_empty;
    assign instruction      = q_empty ? NOP   : q_head.word;
    assign instructionPc    = q_empty ? 32'h0 : q_head.pc;

    fetch_fifo #(.W(64), .DEPTH(QUEUE_DEPTH)) u_ibuf (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (redirectValid),
        .push_i  (resp_keep),
        .pop_i   (q_pop),
        .data_i  (q_in),
        .data_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    fetch_fifo #(.W(32), .DEPTH(QUEUE_DEPTH)) u_inflight (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .pop_i   (resp_trk),
        .data_i  (imemReqAddr),
        .data_o  (fl_head_pc),
        .count_o (fl_count),
        .empty_o (fl_empty),
        .full_o  (fl_full)
    );

    assign out_after_resp = outstanding_q - CW'(resp_trk);

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = out_after_resp;
        drop_d        = drop_q;
        if (req_fire && (out_after_resp < DEPTH_C)) outstanding_d = out_after_resp + 1'b1;
        if (redirectValid) begin
            pc_d   = redirectTarget & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d = out_after_resp;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (resp_trk && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    a_drop_le_out:  assert property (@(posedge clk) disable iff (reset) drop_q <= outstanding_q);
    a_flight_track: assert property (@(posedge clk) disable iff (reset) fl_count == outstanding_q);
    a_no_fl_ovf:    assert property (@(posedge clk) disable iff (reset) !(req_fire && fl_full));
    a_no_q_ovf:     assert property (@(posedge clk) disable iff (reset) !(resp_keep && q_full && !q_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-level reference model.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int          QD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemReqValid, imemReqReady = 1'b0;
    logic [31:0] imemReqAddr;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = '0;
    logic        stall = 1'b0, redirectValid = 1'b0;
    logic [31:0] redirectTarget = '0;
    logic [31:0] instruction, instructionPc;
    logic        instructionValid;

    int nvec = 0;
    int nerr = 0;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .stall(stall), .redirectValid(redirectValid), .redirectTarget(redirectTarget),
        .instruction(instruction), .instructionPc(instructionPc), .instructionValid(instructionValid)
    );

    always #5 clk = ~clk;

    // Reference model: buffered {word,pc}, in-flight pcs, fetch pc, words still to discard.
    logic [31:0] mpc = RPC;
    logic [63:0] mq[$];
    logic [31:0] mfl[$];
    int          mdrop = 0;
    logic [31:0] pend[$];   // addresses the DUT actually handed to memory
    logic        m_req_vld, m_ivld;
    logic [31:0] m_addr, m_instr, m_ipc;
    logic        dut_fire;
    logic [31:0] dut_addr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // rmode: 0 = respond 1 cycle after request, 1 = random, 2 = hold responses
    task automatic drive(input logic rdy, input logic stl, input logic rdr,
                         input logic [31:0] tgt, input logic rst, input int rmode);
        @(negedge clk);
        reset = rst; imemReqReady = rdy; stall = stl; redirectValid = rdr; redirectTarget = tgt;
        imemRespValid = !rst && (pend.size() > 0) && (rmode == 0 || (rmode == 1 && $urandom_range(0, 1) == 1));
        imemRespData  = imemRespValid ? memword(pend[0]) : $urandom;
        if (rst) begin
            m_req_vld = 1'b0; m_addr = RPC; m_ivld = 1'b0; m_instr = NOP; m_ipc = 32'h0;
        end else begin
            m_req_vld = !rdr && ((mfl.size() + mq.size()) < QD);
            m_addr    = {mpc[31:2], 2'b00};
            m_ivld    = mq.size() > 0;
            m_instr   = m_ivld ? mq[0][63:32] : NOP;
            m_ipc     = m_ivld ? mq[0][31:0]  : 32'h0;
        end
        #1;
        dut_fire = imemReqValid && imemReqReady;
        dut_addr = imemReqAddr;
    endtask

    task automatic advance();
        logic [31:0] p;
        logic        resp;
        p = '0;
        @(posedge clk);
        if (reset) begin
            mq.delete(); mfl.delete(); pend.delete(); mdrop = 0; mpc = RPC;
        end else begin
            resp = imemRespValid && (mfl.size() > 0);
            if (resp) p = mfl.pop_front();
            if (redirectValid) begin
                mq.delete();
                mpc   = {redirectTarget[31:2], 2'b00};
                mdrop = mfl.size();
            end else begin
                if (mq.size() > 0 && !stall) void'(mq.pop_front());
                if (resp) begin
                    if (mdrop > 0) mdrop--;
                    else if (mq.size() < QD) mq.push_back({imemRespData, p});
                end
                if (m_req_vld && imemReqReady) begin
                    mfl.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
            if (imemRespValid) void'(pend.pop_front());
            if (dut_fire) pend.push_back(dut_addr);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
            nvec++; if (imemReqValid !== 1'b0) begin nerr++; $display("FAIL reset_reqvld: got %b want 0", imemReqValid); end
            nvec++; if (imemReqAddr !== RPC) begin nerr++; $display("FAIL reset_addr: got %h want %h", imemReqAddr, RPC); end
            nvec++; if (instructionValid !== 1'b0) begin nerr++; $display("FAIL reset_ivld: got %b want 0", instructionValid); end
            nvec++; if (instruction !== NOP) begin nerr++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
            nvec++; if (instructionPc !== 32'h0) begin nerr++; $display("FAIL reset_ipc: got %h want 0", instructionPc); end
            advance();
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] exp_a[3];
        int k = 0;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        for (int c = 0; c < 12 && k < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            if (c == 0) begin
                nvec++; if (imemReqValid !== 1'b1) begin nerr++; $display("FAIL first_req: got %b want 1", imemReqValid); end
            end
            if (dut_fire) begin
                nvec++; if (dut_addr !== exp_a[k]) begin nerr++; $display("FAIL wrap_addr%0d: got %h want %h", k, dut_addr, exp_a[k]); end
                k++;
            end
            advance();
        end
        nvec++; if (k != 3) begin nerr++; $display("FAIL wrap_timeout: got %0d fetches want 3", k); end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
        advance();
        // Raise reset mid-cycle, away from any clock edge.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        nvec++; if (imemReqValid !== 1'b0) begin nerr++; $display("FAIL async_reqvld: got %b want 0", imemReqValid); end
        nvec++; if (imemReqAddr !== RPC) begin nerr++; $display("FAIL async_addr: got %h want %h", imemReqAddr, RPC); end
        nvec++; if (instructionValid !== 1'b0) begin nerr++; $display("FAIL async_ivld: got %b want 0", instructionValid); end
        nvec++; if (instruction !== NOP) begin nerr++; $display("FAIL async_instr: got %h want %h", instruction, NOP); end
        nvec++; if (instructionPc !== 32'h0) begin nerr++; $display("FAIL async_ipc: got %h want 0", instructionPc); end
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        advance();
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc = RPC;
        int delivered = 0;
        for (int c = 0; c < 24; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            nvec++; if (imemReqValid !== m_req_vld) begin nerr++; $display("FAIL stream_reqvld: got %b want %b", imemReqValid, m_req_vld); end
            nvec++; if (imemReqAddr !== m_addr) begin nerr++; $display("FAIL stream_addr: got %h want %h", imemReqAddr, m_addr); end
            nvec++; if (instructionValid !== m_ivld) begin nerr++; $display("FAIL stream_ivld: got %b want %b", instructionValid, m_ivld); end
            if (instructionValid === 1'b1) begin
                nvec++; if (instructionPc !== exp_pc) begin nerr++; $display("FAIL stream_seq: got %h want %h", instructionPc, exp_pc); end
                nvec++; if (instruction !== memword(exp_pc)) begin nerr++; $display("FAIL stream_word: got %h want %h", instruction, memword(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            advance();
        end
        nvec++; if (delivered < 8) begin nerr++; $display("FAIL stream_count: got %0d want >=8", delivered); end
    endtask

    task automatic test_stall_full();
        logic [31:0] exp_pc;
        int found = 0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 0);
        advance();
        for (int c = 0; c < 20 && found == 0; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            nvec++; if (instructionValid !== m_ivld) begin nerr++; $display("FAIL stallpre_ivld: got %b want %b", instructionValid, m_ivld); end
            advance();
            if (mq.size() > 0 && mq[0][31:0] == 32'h4) found = 1;
        end
        nvec++; if (found == 0) begin nerr++; $display("FAIL stall_setup: got no head at 4 want head 00000004"); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0);
            nvec++; if (instructionValid !== 1'b1) begin nerr++; $display("FAIL stall_ivld%0d: got %b want 1", i, instructionValid); end
            nvec++; if (instructionPc !== 32'h4) begin nerr++; $display("FAIL stall_head%0d: got %h want 00000004", i, instructionPc); end
            nvec++; if (imemReqValid !== m_req_vld) begin nerr++; $display("FAIL stall_credit%0d: got %b want %b", i, imemReqValid, m_req_vld); end
            if (i >= 2) begin
                nvec++; if (imemReqValid !== 1'b0) begin nerr++; $display("FAIL stall_full%0d: got %b want 0", i, imemReqValid); end
            end
            advance();
        end
        exp_pc = 32'h4;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            if (instructionValid === 1'b1) begin
                nvec++; if (instructionPc !== exp_pc) begin nerr++; $display("FAIL release_seq: got %h want %h", instructionPc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
            end
            advance();
        end
        nvec++; if (exp_pc < 32'h14) begin nerr++; $display("FAIL release_count: got next %h want >=00000014", exp_pc); end
    endtask

    task automatic test_redirect_inflight();
        int ok = 0;
        for (int c = 0; c < 12 && ok == 0; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2);
            advance();
            if (mfl.size() == 2 && mq.size() == 0) ok = 1;
        end
        nvec++; if (ok == 0) begin nerr++; $display("FAIL rdi_setup: got out=%0d q=%0d want 2/0", mfl.size(), mq.size()); end
        drive(1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 2);
        nvec++; if (imemReqValid !== 1'b0) begin nerr++; $display("FAIL rdi_reqvld: got %b want 0", imemReqValid); end
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        nvec++; if (imemReqAddr !== 32'h100) begin nerr++; $display("FAIL rdi_addr: got %h want 00000100", imemReqAddr); end
        advance();
        ok = 0;
        for (int c = 0; c < 12 && ok == 0; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            nvec++; if (instructionValid !== m_ivld) begin nerr++; $display("FAIL rdi_ivld: got %b want %b", instructionValid, m_ivld); end
            if (instructionValid === 1'b1) begin
                ok = 1;
                nvec++; if (instructionPc !== 32'h100) begin nerr++; $display("FAIL rdi_first_pc: got %h want 00000100", instructionPc); end
                nvec++; if (instruction !== memword(32'h100)) begin nerr++; $display("FAIL rdi_first_word: got %h want %h", instruction, memword(32'h100)); end
            end
            advance();
        end
        nvec++; if (ok == 0) begin nerr++; $display("FAIL rdi_timeout: got no valid instruction want pc 00000100"); end
    endtask

    task automatic test_redirect_coincident();
        int ok = 0;
        for (int c = 0; c < 16 && ok == 0; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            advance();
            if (mq.size() > 0 && pend.size() > 0 && mfl.size() > 0) ok = 1;
        end
        nvec++; if (ok == 0) begin nerr++; $display("FAIL rdc_setup: got no coincident slot want one"); end
        drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        nvec++; if (instructionValid !== 1'b0) begin nerr++; $display("FAIL rdc_empty: got %b want 0", instructionValid); end
        nvec++; if (32'(dut.drop_q) !== 32'(mfl.size())) begin nerr++; $display("FAIL rdc_drop: got %0d want %0d", dut.drop_q, mfl.size()); end
        nvec++; if (32'(dut.outstanding_q) !== 32'(mfl.size())) begin nerr++; $display("FAIL rdc_out: got %0d want %0d", dut.outstanding_q, mfl.size()); end
        advance();
        ok = 0;
        for (int c = 0; c < 12 && ok == 0; c++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
            if (instructionValid === 1'b1) begin
                ok = 1;
                nvec++; if (instructionPc !== 32'h200) begin nerr++; $display("FAIL rdc_first_pc: got %h want 00000200", instructionPc); end
            end
            advance();
        end
        nvec++; if (ok == 0) begin nerr++; $display("FAIL rdc_timeout: got no valid instruction want pc 00000200"); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom, 1'b0, 1);
            nvec++; if (imemReqValid !== m_req_vld) begin nerr++; $display("FAIL rnd_reqvld@%0d: got %b want %b", c, imemReqValid, m_req_vld); end
            nvec++; if (imemReqAddr !== m_addr) begin nerr++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imemReqAddr, m_addr); end
            nvec++; if (instructionValid !== m_ivld) begin nerr++; $display("FAIL rnd_ivld@%0d: got %b want %b", c, instructionValid, m_ivld); end
            nvec++; if (instruction !== m_instr) begin nerr++; $display("FAIL rnd_instr@%0d: got %h want %h", c, instruction, m_instr); end
            nvec++; if (instructionPc !== m_ipc) begin nerr++; $display("FAIL rnd_ipc@%0d: got %h want %h", c, instructionPc, m_ipc); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_wrap_reset();
        test_streaming();
        test_stall_full();
        test_redirect_inflight();
        test_redirect_coincident();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1);
    end
endmodule
